// File: rtl/cpu_pkg.sv
// Shared CPU types for the fetch/decode boundary.
// Fetch packet layout and HALT opcode.
package cpu_pkg;

  localparam int WORD_W = 32;
  localparam logic [5:0] OPC_HALT = 6'b000000;

  typedef struct packed {
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] pc4;
  } fetch_pkt_t;

  function automatic logic is_halt(
    input logic [WORD_W-1:0] instr
  );
    return instr[WORD_W-1 -: 6] == OPC_HALT;
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch/decode queue handshake bundle.
// master = fetch+decode side, slave = queue.
interface fetch_queue_if #(
  parameter int DEPTH  = 4,
  parameter int WORD_W = 32
);

  localparam int CW = $clog2(DEPTH + 1);

  logic              in_valid;
  logic [WORD_W-1:0] in_instr;
  logic [WORD_W-1:0] in_pc;
  logic [WORD_W-1:0] in_pc4;
  logic              in_ready;
  logic              flush;
  logic              out_valid;
  logic [WORD_W-1:0] out_instr;
  logic [WORD_W-1:0] out_pc;
  logic [WORD_W-1:0] out_pc4;
  logic              out_ready;
  logic [CW-1:0]     count;
  logic              halt_seen;

  modport master (
    output in_valid, in_instr, in_pc, in_pc4,
    output flush, out_ready,
    input  in_ready, out_valid,
    input  out_instr, out_pc, out_pc4,
    input  count, halt_seen
  );

  modport slave (
    input  in_valid, in_instr, in_pc, in_pc4,
    input  flush, out_ready,
    output in_ready, out_valid,
    output out_instr, out_pc, out_pc4,
    output count, halt_seen
  );

endinterface

// File: rtl/fetchq_ram.sv
// Fetch queue storage: one sync write port,
// one combinational read port, data not reset.
module fetchq_ram
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  fetch_pkt_t    wdata,
  input  logic [AW-1:0] raddr,
  output fetch_pkt_t    rdata
);

  fetch_pkt_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Fetch->decode instruction queue with one-cycle flush and HALT tracking.
// Define FETCHQ_BYPASS_EN for a zero-latency path when the queue is empty.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  fetch_queue_if.slave  bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0] rd_ptr_q, rd_ptr_d;
  logic        halt_seen_q, halt_seen_d;

  logic        empty;
  logic        full;
  logic        in_ready;
  logic        accept;
  logic        byp;
  logic        byp_take;
  logic        push;
  logic        pop;
  fetch_pkt_t  in_pkt;
  fetch_pkt_t  head_pkt;
  fetch_pkt_t  out_pkt;

  fetchq_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q[PW-1:0]),
    .wdata (in_pkt),
    .raddr (rd_ptr_q[PW-1:0]),
    .rdata (head_pkt)
  );

  always_comb begin
    in_pkt = '{
      instr: bus.in_instr,
      pc:    bus.in_pc,
      pc4:   bus.in_pc4
    };
    empty = wr_ptr_q == rd_ptr_q;
    full  = (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0])
         && (wr_ptr_q[PW] != rd_ptr_q[PW]);
    in_ready = !full && !halt_seen_q;
    accept   = bus.in_valid && in_ready && !bus.flush;
`ifdef FETCHQ_BYPASS_EN
    byp      = empty && accept;
    byp_take = byp && bus.out_ready;
`else
    byp      = 1'b0;
    byp_take = 1'b0;
`endif
    push = accept && !byp_take;
    pop  = !empty && bus.out_ready && !bus.flush;
    out_pkt = '0;
    if (!empty) begin
      out_pkt = head_pkt;
    end
`ifdef FETCHQ_BYPASS_EN
    else if (byp) begin
      out_pkt = in_pkt;
    end
`endif
  end

  // flush wins over any same-cycle push/pop
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    halt_seen_d = halt_seen_q;
    if (bus.flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      halt_seen_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (accept && is_halt(bus.in_instr)) begin
        halt_seen_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      halt_seen_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      halt_seen_q <= halt_seen_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = !empty || byp;
  assign bus.out_instr = out_pkt.instr;
  assign bus.out_pc    = out_pkt.pc;
  assign bus.out_pc4   = out_pkt.pc4;
  assign bus.count     = CW'(wr_ptr_q - rd_ptr_q);
  assign bus.halt_seen = halt_seen_q;

endmodule
